// File: rtl/sd_card_cmd_rx_pkg.sv
// Shared definitions for the SD card-side command receiver: frame geometry,
// field offsets within the 48-bit frame, FSM states and the CRC7 step.
package sd_card_cmd_rx_pkg;

    localparam int SD_CMD_FRAME_BITS = 48;
    localparam int SD_CRC_BITS       = 7;
    localparam int SD_IDX_BITS       = 6;
    localparam int SD_ARG_BITS       = 32;

    localparam logic [SD_CRC_BITS-1:0] SD_CRC7_POLY = 7'h09;

    localparam int SD_START_BIT = 47;
    localparam int SD_TX_BIT    = 46;
    localparam int SD_IDX_MSB   = 45;
    localparam int SD_IDX_LSB   = 40;
    localparam int SD_ARG_MSB   = 39;
    localparam int SD_ARG_LSB   = 8;
    localparam int SD_CRC_MSB   = 7;
    localparam int SD_CRC_LSB   = 1;
    localparam int SD_END_BIT   = 0;

    // Start, transmission, index and argument bits are covered by CRC7.
    localparam int SD_CRC_DATA_BITS = SD_CMD_FRAME_BITS - SD_CRC_BITS - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } sd_rx_state_e;

    function automatic logic [SD_CRC_BITS-1:0] crc7_step(
        input logic [SD_CRC_BITS-1:0] crc,
        input logic                   bit_in
    );
        logic fb;
        fb = bit_in ^ crc[SD_CRC_BITS-1];
        return {crc[SD_CRC_BITS-2:0], 1'b0} ^ (fb ? SD_CRC7_POLY : '0);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 LFSR (x^7+x^3+1), MSB-first. clr_i restarts from zero; when
// clr_i and en_i coincide the data bit is shifted into a cleared register.
module sd_crc7
    import sd_card_cmd_rx_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic                   bit_i,
    output logic [SD_CRC_BITS-1:0] crc_o
);

    logic [SD_CRC_BITS-1:0] crc_q;
    logic [SD_CRC_BITS-1:0] crc_d;
    logic [SD_CRC_BITS-1:0] base;

    always_comb begin
        base  = clr_i ? '0 : crc_q;
        crc_d = crc_q;
        if (en_i) begin
            crc_d = crc7_step(base, bit_i);
        end else if (clr_i) begin
            crc_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_card_cmd_rx.sv
// Card-side SD command receiver: deserialises a 48-bit CMD frame, checks
// transmission bit, end bit and CRC7, and strobes the decoded result once.
module sd_card_cmd_rx
    import sd_card_cmd_rx_pkg::*;
#(
    parameter int FRAME_BITS = SD_CMD_FRAME_BITS,
    parameter int CRC_BITS   = SD_CRC_BITS,
    parameter int IDX_BITS   = SD_IDX_BITS,
    parameter int ARG_BITS   = SD_ARG_BITS
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Enable,
    input  logic                serial_in,
    output logic [IDX_BITS-1:0] cmd_index,
    output logic [ARG_BITS-1:0] cmd_arg,
    output logic                cmd_valid,
    output logic                crc_error,
    output logic                frame_error,
    output logic                busy
);

    localparam int CNT_W = $clog2(FRAME_BITS);

    sd_rx_state_e           state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [FRAME_BITS-3:0]  shift_q;
    logic [FRAME_BITS-2:0]  shift_d;
    logic [IDX_BITS-1:0]    index_q;
    logic [ARG_BITS-1:0]    arg_q;
    logic                   valid_q;
    logic                   crc_err_q;
    logic                   frame_err_q;
    logic                   busy_q;

    logic [CRC_BITS-1:0]    crc_calc;
    logic                   crc_clr;
    logic                   crc_en;
    logic                   fmt_bad;
    logic                   crc_bad;
    logic                   last_bit;

    // shift_d is the frame with the start bit dropped, so bit positions match
    // the 48-bit field offsets once the end bit is the incoming sample.
    assign shift_d  = {shift_q, serial_in};
    assign fmt_bad  = ~shift_d[SD_TX_BIT] | ~shift_d[SD_END_BIT];
    assign crc_bad  = shift_d[SD_CRC_MSB:SD_CRC_LSB] != crc_calc;
    assign last_bit = cnt_q == CNT_W'(FRAME_BITS - 1);

    assign crc_clr = state_q != ST_RECV;
    assign crc_en  = Enable & (((state_q == ST_IDLE) & ~serial_in) |
                               ((state_q == ST_RECV) & (cnt_q < CNT_W'(SD_CRC_DATA_BITS))));

    sd_crc7 u_crc7 (
        .clk_i (Clock),
        .rst_i (Reset),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .bit_i (serial_in),
        .crc_o (crc_calc)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            index_q     <= '0;
            arg_q       <= '0;
            valid_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Enable && !serial_in) begin
                        state_q <= ST_RECV;
                        cnt_q   <= CNT_W'(1);
                        busy_q  <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (Enable) begin
                        shift_q <= shift_d[FRAME_BITS-3:0];
                        if (last_bit) begin
                            state_q     <= ST_DONE;
                            cnt_q       <= '0;
                            busy_q      <= 1'b0;
                            index_q     <= shift_d[SD_IDX_MSB:SD_IDX_LSB];
                            arg_q       <= shift_d[SD_ARG_MSB:SD_ARG_LSB];
                            frame_err_q <= fmt_bad;
                            crc_err_q   <= ~fmt_bad & crc_bad;
                            valid_q     <= ~fmt_bad & ~crc_bad;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_index   = index_q;
    assign cmd_arg     = arg_q;
    assign cmd_valid   = valid_q;
    assign crc_error   = crc_err_q;
    assign frame_error = frame_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sd_card_cmd_rx.sv
// Self-checking bench for sd_card_cmd_rx: vector table of frames with a
// scoreboard of expected results, plus stall, reset-abort and DONE-start cases.
module tb_sd_card_cmd_rx;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        serial_in;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_valid;
    logic        crc_error;
    logic        frame_error;
    logic        busy;

    always #5 Clock = ~Clock;

    sd_card_cmd_rx #(
        .FRAME_BITS (48),
        .CRC_BITS   (7),
        .IDX_BITS   (6),
        .ARG_BITS   (32)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Enable      (Enable),
        .serial_in   (serial_in),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .cmd_valid   (cmd_valid),
        .crc_error   (crc_error),
        .frame_error (frame_error),
        .busy        (busy)
    );

    typedef struct {
        logic        v;
        logic        ce;
        logic        fe;
        logic [5:0]  idx;
        logic [31:0] arg;
    } exp_t;

    typedef struct {
        logic [47:0] frame;
        int unsigned gap;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard consumer: every result pulse must match the oldest expectation.
    always @(negedge Clock) begin
        if (cmd_valid || crc_error || frame_error) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {61'd0, cmd_valid, crc_error, frame_error}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("cmd_valid",   64'(cmd_valid),   64'(e.v));
                check("crc_error",   64'(crc_error),   64'(e.ce));
                check("frame_error", 64'(frame_error), 64'(e.fe));
                check("cmd_index",   64'(cmd_index),   64'(e.idx));
                check("cmd_arg",     64'(cmd_arg),     64'(e.arg));
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic idle_bits(input int unsigned n, input logic [5:0] hold_idx);
        for (int unsigned i = 0; i < n; i++) begin
            serial_in = 1'b1;
            Enable    = 1'b1;
            tick();
            check("index_hold", 64'(cmd_index), 64'(hold_idx));
        end
    endtask

    // Sends a frame MSB-first; stall inserts two Enable=0 cycles after each bit.
    // done_bit is the serial level driven during the DONE cycle.
    task automatic send_frame(input logic [47:0] f, input bit stall, input logic done_bit, input exp_t e);
        sb.push_back(e);
        for (int b = 47; b >= 0; b--) begin
            serial_in = f[b];
            Enable    = 1'b1;
            tick();
            if (stall && b > 0) begin
                Enable = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    tick();
                    check("busy_pause", 64'(busy), 64'd1);
                end
            end
        end
        serial_in = done_bit;
        Enable    = 1'b1;
        check("latency_pulse", 64'(cmd_valid | crc_error | frame_error), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
        tick();
        serial_in = 1'b1;
        check("pulse_one_cycle", 64'(cmd_valid | crc_error | frame_error), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_index"}, 64'(cmd_index), 64'd0);
        check({tag, "_arg"},   64'(cmd_arg),   64'd0);
        check({tag, "_flags"}, {60'd0, cmd_valid, crc_error, frame_error, busy}, 64'd0);
    endtask

    vec_t vecs[6];
    exp_t ex;

    initial begin
        vecs[0] = '{48'h40_00000000_95, 0, '{1'b1, 1'b0, 1'b0, 6'd0,  32'h0}};
        vecs[1] = '{48'h48_000001AA_87, 2, '{1'b1, 1'b0, 1'b0, 6'd8,  32'h1AA}};
        vecs[2] = '{48'h51_00000000_55, 3, '{1'b1, 1'b0, 1'b0, 6'd17, 32'h0}};
        vecs[3] = '{48'h40_00000000_97, 1, '{1'b0, 1'b1, 1'b0, 6'd0,  32'h0}};
        vecs[4] = '{48'h48_000001AA_86, 1, '{1'b0, 1'b0, 1'b1, 6'd8,  32'h1AA}};
        vecs[5] = '{48'h08_000001AA_87, 1, '{1'b0, 1'b0, 1'b1, 6'd8,  32'h1AA}};

        Reset     = 1'b1;
        Enable    = 1'b0;
        serial_in = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check_cleared("reset");
        Reset = 1'b0;
        idle_bits(2, 6'd0);

        foreach (vecs[i]) begin
            send_frame(vecs[i].frame, 1'b0, 1'b1, vecs[i].e);
            idle_bits(vecs[i].gap, vecs[i].e.idx);
        end

        // Start bit during DONE must be ignored.
        ex = '{1'b1, 1'b0, 1'b0, 6'd17, 32'h0};
        send_frame(48'h51_00000000_55, 1'b0, 1'b0, ex);
        idle_bits(1, 6'd17);
        check("done_start_ignored", 64'(busy), 64'd0);

        // Enable pattern 1,0,0 pauses the frame without losing bits.
        ex = '{1'b1, 1'b0, 1'b0, 6'd0, 32'h0};
        send_frame(48'h40_00000000_95, 1'b1, 1'b1, ex);
        idle_bits(1, 6'd0);

        // Load a non-zero index, then abort a frame with reset after 20 bits.
        ex = '{1'b1, 1'b0, 1'b0, 6'd8, 32'h1AA};
        send_frame(48'h48_000001AA_87, 1'b0, 1'b1, ex);
        idle_bits(1, 6'd8);
        begin
            logic [47:0] fr;
            fr = 48'h48_000001AA_87;
            for (int b = 47; b > 27; b--) begin
                serial_in = fr[b];
                Enable    = 1'b1;
                tick();
            end
        end
        check("busy_mid_frame", 64'(busy), 64'd1);
        Reset     = 1'b1;
        serial_in = 1'b1;
        tick();
        check_cleared("abort_reset");
        Reset = 1'b0;
        idle_bits(30, 6'd0);

        ex = '{1'b1, 1'b0, 1'b0, 6'd0, 32'h0};
        send_frame(48'h40_00000000_95, 1'b0, 1'b1, ex);
        idle_bits(2, 6'd0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
